// File: rtl/sm_accumulator.sv
// ============================================================================
// sm_accumulator
// ----------------------------------------------------------------------------
// Running sign-magnitude accumulator that sits downstream of the sign-magnitude
// adder. Operand beats arrive over a valid/ready handshake and are summed with
// the adder's rules. When the beat marked last is accepted, the final sum,
// beat count and sticky overflow flag are held on the outputs until the
// consumer accepts them. The accumulator then clears for the next packet.
//
// Ports:
//   clk        single clock, all state on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operand beat present
//   in_ready   stage can accept a beat (high in ACC)
//   in_sign    operand sign (1 = negative)
//   in_mag     operand magnitude, N bits
//   in_last    marks the final beat of a packet
//   out_valid  result available (high in OUT)
//   out_ready  consumer accepts the result
//   out_sign   result sign
//   out_mag    result magnitude, N bits
//   out_ovf    sticky overflow/saturation flag for the packet
//   out_count  beats accepted in the packet, saturating, COUNT_W bits
// ============================================================================
module sm_accumulator #(
    parameter int N       = 4,
    parameter int COUNT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sign,
    input  logic [N-1:0]       in_mag,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_sign,
    output logic [N-1:0]       out_mag,
    output logic               out_ovf,
    output logic [COUNT_W-1:0] out_count
);

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } state_t;

    state_t             state;
    logic               acc_sign;
    logic [N-1:0]       acc_mag;
    logic [COUNT_W-1:0] count;
    logic               ovf;

    logic               op_sign;
    logic [N:0]         sum;
    logic               nxt_sign;
    logic [N-1:0]       nxt_mag;
    logic               nxt_ovf;

    // Sign-magnitude add of the accumulator and the incoming operand. A zero
    // operand is forced to +0 so it always takes the same-sign path when the
    // accumulator is non-negative and never flips the sign of the result.
    always_comb begin
        op_sign  = in_sign & (in_mag != '0);
        sum      = {1'b0, acc_mag} + {1'b0, in_mag};
        nxt_sign = acc_sign;
        nxt_mag  = acc_mag;
        nxt_ovf  = 1'b0;
        if (op_sign == acc_sign) begin
            if (sum[N]) begin
                nxt_mag = '1;
                nxt_ovf = 1'b1;
            end else begin
                nxt_mag = sum[N-1:0];
            end
        end else if (acc_mag >= in_mag) begin
            nxt_mag = acc_mag - in_mag;
        end else begin
            nxt_mag  = in_mag - acc_mag;
            nxt_sign = op_sign;
        end
        // Negative zero is never allowed out of the adder.
        if (nxt_mag == '0) begin
            nxt_sign = 1'b0;
        end
    end

    // Handshake flags are registered alongside the state so every output of
    // the block comes straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACC;
            acc_sign  <= 1'b0;
            acc_mag   <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (in_valid) begin
                        if (count != '1) begin
                            count <= count + 1'b1;
                        end
                        // After saturation the sum is frozen, but beats are
                        // still counted until the packet ends.
                        if (!ovf) begin
                            acc_sign <= nxt_sign;
                            acc_mag  <= nxt_mag;
                            ovf      <= nxt_ovf;
                        end
                        if (in_last) begin
                            state     <= OUT;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state     <= ACC;
                        acc_sign  <= 1'b0;
                        acc_mag   <= '0;
                        count     <= '0;
                        ovf       <= 1'b0;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ACC;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_sign  = acc_sign;
    assign out_mag   = acc_mag;
    assign out_ovf   = ovf;
    assign out_count = count;

endmodule

// File: tb/tb_sm_accumulator.sv
// ============================================================================
// tb_sm_accumulator
// ----------------------------------------------------------------------------
// Scoreboard bench for sm_accumulator. The stimulus process drives operand
// packets and pushes the expected result of each completed packet, computed
// with plain signed integer arithmetic, into a queue. A separate monitor pops
// and compares whenever a result is handed off, and also watches hold
// stability, in_ready/out_valid exclusivity and the clear after handoff.
// ============================================================================
module tb_sm_accumulator;

    localparam int N       = 4;
    localparam int COUNT_W = 4;
    localparam int MAXM    = (1 << N) - 1;
    localparam int MAXC    = (1 << COUNT_W) - 1;

    typedef struct packed {
        logic               s;
        logic [N-1:0]       m;
        logic               o;
        logic [COUNT_W-1:0] c;
    } exp_t;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic               in_sign;
    logic [N-1:0]       in_mag;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic               out_sign;
    logic [N-1:0]       out_mag;
    logic               out_ovf;
    logic [COUNT_W-1:0] out_count;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   ready_mode = 1;   // 0 random, 1 always high, 2 always low
    exp_t sb[$];

    // Reference model: value as a signed integer, sticky overflow, beat count
    int   m_val   = 0;
    bit   m_ovf   = 0;
    int   m_beats = 0;

    sm_accumulator #(.N(N), .COUNT_W(COUNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_mag    (in_mag),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_mag   (out_mag),
        .out_ovf   (out_ovf),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Consumer side: out_ready changes just after each rising edge
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0)      out_ready = 1'($urandom % 2);
            else if (ready_mode == 1) out_ready = 1'b1;
            else                      out_ready = 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_val   = 0;
        m_ovf   = 0;
        m_beats = 0;
    endtask

    task automatic modelBeat(input logic s, input logic [N-1:0] m, input logic last);
        int   op;
        int   t;
        exp_t e;
        op = s ? -int'(m) : int'(m);
        if (!m_ovf) begin
            t = m_val + op;
            if (t > MAXM) begin
                m_val = MAXM;
                m_ovf = 1;
            end else if (t < -MAXM) begin
                m_val = -MAXM;
                m_ovf = 1;
            end else begin
                m_val = t;
            end
        end
        m_beats++;
        if (last) begin
            e.s = (m_val < 0);
            e.m = N'((m_val < 0) ? -m_val : m_val);
            e.o = m_ovf;
            e.c = COUNT_W'((m_beats > MAXC) ? MAXC : m_beats);
            sb.push_back(e);
            modelReset();
        end
    endtask

    // Drive one beat and hold it until the DUT accepts it; returns at posedge+1
    task automatic applyStimulus(input logic s, input logic [N-1:0] m, input logic last);
        bit accepted = 0;
        in_valid = 1'b1;
        in_sign  = s;
        in_mag   = m;
        in_last  = last;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1;
                break;
            end
        end
        if (accepted) begin
            @(posedge clk);
            #1;
            modelBeat(s, m, last);
            if (last) checkOutput("out_valid_latency", 32'(out_valid), 32'd1);
        end else begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic waitIdle();
        bit done = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!out_valid && sb.size() == 0) begin
                done = 1;
                break;
            end
        end
        if (!done) checkOutput("drain_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every handoff, checks hold stability
    // under backpressure and the cleared state after each handoff.
    initial begin
        bit   hold = 0;
        bit   chk_clear = 0;
        exp_t snap;
        exp_t got;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold      = 0;
                chk_clear = 0;
            end else begin
                if (chk_clear) begin
                    checkOutput("clr_valid", 32'(out_valid), 32'd0);
                    checkOutput("clr_ready", 32'(in_ready), 32'd1);
                    checkOutput("clr_mag",   32'(out_mag), 32'd0);
                    checkOutput("clr_sign",  32'(out_sign), 32'd0);
                    checkOutput("clr_count", 32'(out_count), 32'd0);
                    checkOutput("clr_ovf",   32'(out_ovf), 32'd0);
                    chk_clear = 0;
                end
                checkOutput("in_ready_excl", 32'(in_ready), 32'(!out_valid));
                if (out_valid) begin
                    if (hold) begin
                        checkOutput("hold_sign",  32'(out_sign), 32'(snap.s));
                        checkOutput("hold_mag",   32'(out_mag), 32'(snap.m));
                        checkOutput("hold_ovf",   32'(out_ovf), 32'(snap.o));
                        checkOutput("hold_count", 32'(out_count), 32'(snap.c));
                    end
                    if (out_ready) begin
                        if (sb.size() == 0) begin
                            checkOutput("unexpected_result", 32'd1, 32'd0);
                        end else begin
                            got = sb.pop_front();
                            checkOutput("res_sign",  32'(out_sign), 32'(got.s));
                            checkOutput("res_mag",   32'(out_mag), 32'(got.m));
                            checkOutput("res_ovf",   32'(out_ovf), 32'(got.o));
                            checkOutput("res_count", 32'(out_count), 32'(got.c));
                        end
                        chk_clear = 1;
                        hold      = 0;
                    end else begin
                        hold   = 1;
                        snap.s = out_sign;
                        snap.m = out_mag;
                        snap.o = out_ovf;
                        snap.c = out_count;
                    end
                end else begin
                    hold = 0;
                end
            end
        end
    end

    initial begin
        int len;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sign  = 1'b0;
        in_mag   = '0;
        in_last  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_mag",   32'(out_mag), 32'd0);
        checkOutput("rst_sign",  32'(out_sign), 32'd0);
        checkOutput("rst_count", 32'(out_count), 32'd0);
        checkOutput("rst_ovf",   32'(out_ovf), 32'd0);
        rst = 1'b0;
        modelReset();

        // Basic add, negative add, cancellation to +0
        applyStimulus(1'b0, 4'd10, 1'b0);
        applyStimulus(1'b0, 4'd2,  1'b1);
        waitIdle();
        applyStimulus(1'b1, 4'd9, 1'b0);
        applyStimulus(1'b1, 4'd5, 1'b1);
        waitIdle();
        applyStimulus(1'b0, 4'd5, 1'b0);
        applyStimulus(1'b1, 4'd5, 1'b1);
        waitIdle();

        // Overflow saturates and freezes the sum
        applyStimulus(1'b1, 4'd8, 1'b0);
        applyStimulus(1'b1, 4'd9, 1'b0);
        applyStimulus(1'b0, 4'd3, 1'b1);
        waitIdle();

        // Backpressure with in_valid held high while the result waits
        applyStimulus(1'b0, 4'd7, 1'b0);
        ready_mode = 2;
        applyStimulus(1'b1, 4'd6, 1'b1);
        in_valid = 1'b1;
        in_sign  = 1'b0;
        in_mag   = 4'd9;
        in_last  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        ready_mode = 1;
        waitIdle();

        // Reset in the middle of a packet discards it
        applyStimulus(1'b0, 4'd4, 1'b0);
        applyStimulus(1'b0, 4'd3, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
        checkOutput("mid_rst_mag",   32'(out_mag), 32'd0);
        checkOutput("mid_rst_sign",  32'(out_sign), 32'd0);
        checkOutput("mid_rst_count", 32'(out_count), 32'd0);
        checkOutput("mid_rst_ovf",   32'(out_ovf), 32'd0);
        checkOutput("mid_rst_ready", 32'(in_ready), 32'd1);
        checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
        applyStimulus(1'b0, 4'd1, 1'b1);
        waitIdle();

        // Single negative-zero beat, then a count-saturating packet
        applyStimulus(1'b1, 4'd0, 1'b1);
        waitIdle();
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 4'd0, 1'(i == 15));
        waitIdle();

        // Randomised packets with random consumer backpressure and gaps
        ready_mode = 0;
        for (int p = 0; p < 40; p++) begin
            len = ($urandom % 8 == 0) ? int'($urandom_range(16, 19)) : int'($urandom_range(1, 6));
            for (int b = 0; b < len; b++) begin
                applyStimulus(1'($urandom % 2), N'($urandom_range(0, MAXM)), 1'(b == len - 1));
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
        end
        ready_mode = 1;
        waitIdle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
